// File: rtl/otter_mem_arbiter.sv
// Arbitrates one single-ported synchronous OTTER memory between IF, D and X requesters.
// Define OTTER_ARB_RR_EN for round-robin arbitration; otherwise fixed priority D > IF > X.
module otter_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  input  logic            x_req,
  input  logic            x_we,
  input  logic [DW/8-1:0] x_be,
  input  logic [AW-1:0]   x_addr,
  input  logic [DW-1:0]   x_wdata,
  output logic            x_gnt,
  output logic            x_rvalid,
  output logic [DW-1:0]   x_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic [1:0] {OWN_D = 2'd0, OWN_IF = 2'd1, OWN_X = 2'd2, OWN_NONE = 2'd3} owner_t;

  state_t     state, state_nx;
  owner_t     owner, owner_nx;
  logic [2:0] lat_cnt, lat_cnt_nx;
  logic [2:0] req_vec;
  logic       win_vld;
  logic [1:0] win_idx;

  // Requester index: 0 = D, 1 = IF, 2 = X
  assign req_vec = {x_req, if_req, d_req};

`ifdef OTTER_ARB_RR_EN
  logic [1:0]      rr_ptr;
  logic [2:0][1:0] order;

  // order[0] is searched first; scanning downward lets the earliest hit win
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    case (rr_ptr)
      2'd1:    order = {2'd1, 2'd0, 2'd2};
      2'd2:    order = {2'd2, 2'd1, 2'd0};
      default: order = {2'd0, 2'd2, 2'd1};
    endcase
    for (int k = 2; k >= 0; k--) begin
      if (req_vec[order[k]]) begin
        win_vld = 1'b1;
        win_idx = order[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST)                        rr_ptr <= 2'd0;
    else if (d_gnt | if_gnt | x_gnt) rr_ptr <= win_idx;
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (req_vec[k]) begin
        win_vld = 1'b1;
        win_idx = 2'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= IDLE;
      lat_cnt <= '0;
      owner   <= OWN_NONE;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      owner   <= owner_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    lat_cnt_nx = lat_cnt;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    x_gnt      = 1'b0;
    if_rvalid  = 1'b0;
    d_rvalid   = 1'b0;
    x_rvalid   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            mem_en = 1'b1;
            case (win_idx)
              2'd0: begin
                d_gnt     = 1'b1;
                mem_we    = d_we;
                mem_be    = d_be;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
              end
              2'd1: begin
                if_gnt   = 1'b1;
                mem_be   = '1;
                mem_addr = if_addr;
              end
              default: begin
                x_gnt     = 1'b1;
                mem_we    = x_we;
                mem_be    = x_be;
                mem_addr  = x_addr;
                mem_wdata = x_wdata;
              end
            endcase
            // Writes complete on the grant edge; only reads occupy the memory
            if (!mem_we) begin
              state_nx   = RD_WAIT;
              owner_nx   = owner_t'(win_idx);
              lat_cnt_nx = 3'(MEM_LAT);
            end
          end
        end
        RD_WAIT: begin
          busy       = 1'b1;
          lat_cnt_nx = lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            case (owner)
              OWN_D:   d_rvalid  = 1'b1;
              OWN_IF:  if_rvalid = 1'b1;
              OWN_X:   x_rvalid  = 1'b1;
              default: ;
            endcase
            state_nx = IDLE;
            owner_nx = OWN_NONE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign x_rdata  = mem_rdata;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: MEM_LAT=1 and MEM_LAT=3 instances share stimulus,
// each checked every cycle against a transaction-level model of grants and read timing.
module tb_otter_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RST;
  logic          if_req, d_req, x_req, d_we, x_we;
  logic [AW-1:0] if_addr, d_addr, x_addr;
  logic [BW-1:0] d_be, x_be;
  logic [DW-1:0] d_wdata, x_wdata;

  // Per instance (0: MEM_LAT=1, 1: MEM_LAT=3); requester index 0=D, 1=IF, 2=X
  logic [2:0]    gnt_a [2];
  logic [2:0]    rv_a [2];
  logic [DW-1:0] rd_a [2][3];
  logic          men_a [2], mwe_a [2], busy_a [2];
  logic [BW-1:0] mbe_a [2];
  logic [AW-1:0] maddr_a [2];
  logic [DW-1:0] mwd_a [2];

  function automatic logic [31:0] init_word(int j);
    return 32'hC0DE_0000 ^ (32'(j) * 32'h0101_0101);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, x_gnt, x_rvalid;
    logic [DW-1:0] if_rdata, d_rdata, x_rdata, mem_rdata, mem_wdata;
    logic          mem_en, mem_we, busy;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] store [16];
    logic [DW-1:0] rd_pipe [LAT];

    otter_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .x_req(x_req), .x_we(x_we), .x_be(x_be), .x_addr(x_addr), .x_wdata(x_wdata),
      .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory macro: word index addr[5:2], read data emerges LAT cycles after the strobe
    initial for (int j = 0; j < 16; j++) store[j] <= init_word(j);
    always @(posedge clk) begin
      if (mem_en && mem_we)
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) store[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      rd_pipe[0] <= (mem_en && !mem_we) ? store[mem_addr[5:2]] : 32'h0;
      for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    assign gnt_a[g]    = {x_gnt, if_gnt, d_gnt};
    assign rv_a[g]     = {x_rvalid, if_rvalid, d_rvalid};
    assign rd_a[g][0]  = d_rdata;
    assign rd_a[g][1]  = if_rdata;
    assign rd_a[g][2]  = x_rdata;
    assign men_a[g]    = mem_en;
    assign mwe_a[g]    = mem_we;
    assign busy_a[g]   = busy;
    assign mbe_a[g]    = mem_be;
    assign maddr_a[g]  = mem_addr;
    assign mwd_a[g]    = mem_wdata;
  end

  int n_chk = 0, n_fail = 0, cyc = 0;
  int issue [2], own [2], rr [2];
  logic [31:0] exp_rd [2];
  logic [31:0] shadow [2][16];

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat%0d cyc%0d: observed %h expected %h", tag, (i == 0) ? 1 : 3, cyc, obs, exp);
    end
  endtask

  // Model: a read granted at cycle t occupies t+1..t+LAT with rvalid at t+LAT
  task automatic check_inst(int i);
    int lat, d, w, base, idx;
    logic       in_wait;
    logic [2:0] rq, eg, ev;
    logic       we_s [3];
    logic [3:0] be_s [3];
    logic [31:0] a_s [3], wd_s [3];
    lat = (i == 0) ? 1 : 3;
    rq = {x_req, if_req, d_req};
    we_s[0] = d_we;  be_s[0] = d_be;  a_s[0] = d_addr;  wd_s[0] = d_wdata;
    we_s[1] = 1'b0;  be_s[1] = 4'hF;  a_s[1] = if_addr; wd_s[1] = 32'h0;
    we_s[2] = x_we;  be_s[2] = x_be;  a_s[2] = x_addr;  wd_s[2] = x_wdata;
    d = cyc - issue[i];
    in_wait = (d >= 1) && (d <= lat);
    eg = '0; ev = '0; w = -1;
`ifdef OTTER_ARB_RR_EN
    base = rr[i] + 1;
`else
    base = 0;
`endif
    if (!RST) begin
      if (in_wait) begin
        if (d == lat) ev[own[i]] = 1'b1;
      end else begin
        for (int k = 0; k < 3; k++) begin
          idx = (base + k) % 3;
          if (w < 0 && rq[idx]) w = idx;
        end
        if (w >= 0) eg[w] = 1'b1;
      end
    end
    chk("gnt", i, 32'(gnt_a[i]), 32'(eg));
    chk("rvalid", i, 32'(rv_a[i]), 32'(ev));
    chk("mem_en", i, 32'(men_a[i]), 32'(w >= 0));
    chk("mem_we", i, 32'(mwe_a[i]), 32'((w >= 0) && we_s[(w >= 0) ? w : 0]));
    chk("busy", i, 32'(busy_a[i]), 32'(!RST && in_wait));
    if (!RST && !in_wait) begin
      chk("mem_addr", i, maddr_a[i], (w >= 0) ? a_s[w] : 32'h0);
      chk("mem_be", i, 32'(mbe_a[i]), (w >= 0) ? 32'(be_s[w]) : 32'h0);
      if (w != 1) chk("mem_wdata", i, mwd_a[i], (w >= 0) ? wd_s[w] : 32'h0);
    end
    if (ev != 3'b0) chk("rdata", i, rd_a[i][own[i]], exp_rd[i]);
    if (RST) begin
      issue[i] = -1000;
      rr[i] = 0;
    end else if (w >= 0) begin
      rr[i] = w;
      if (we_s[w]) begin
        for (int b = 0; b < 4; b++)
          if (be_s[w][b]) shadow[i][a_s[w][5:2]][8*b +: 8] = wd_s[w][8*b +: 8];
      end else begin
        issue[i] = cyc;
        own[i] = w;
        exp_rd[i] = shadow[i][a_s[w][5:2]];
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    if_req = 0; d_req = 0; x_req = 0; d_we = 0; x_we = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h2000 + 32'($urandom_range(0, 15) << 2);
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      issue[i] = -1000; own[i] = 0; rr[i] = 0; exp_rd[i] = '0;
      for (int j = 0; j < 16; j++) shadow[i][j] = init_word(j);
    end
    // Reset held with every requester asserted
    RST = 1;
    if_req = 1; d_req = 1; x_req = 1; d_we = 0; x_we = 0;
    d_be = 4'hF; x_be = 4'hF; d_addr = 32'h2004; if_addr = 32'h2008; x_addr = 32'h200C;
    d_wdata = $urandom; x_wdata = $urandom;
    repeat (2) cycle();
    // Three-way contention of reads
    RST = 0;
    repeat (8) cycle();
    set_idle(); cycle();
    // Single IF read
    if_req = 1; if_addr = 32'h100; cycle();
    set_idle(); repeat (4) cycle();
    // Partial D write, then read back the merged word
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; cycle();
    set_idle(); cycle();
    d_req = 1; d_we = 0; d_addr = 32'h2000; cycle();
    set_idle(); repeat (4) cycle();
    // X read with IF arriving during the wait
    x_req = 1; x_we = 0; x_be = 4'hF; x_addr = 32'h2010; cycle();
    set_idle(); if_req = 1; if_addr = 32'h2014; repeat (5) cycle();
    set_idle(); repeat (4) cycle();
    // Reset right after a D read grant, IF pending
    d_req = 1; d_we = 0; d_addr = 32'h2000; cycle();
    set_idle(); if_req = 1; if_addr = 32'h2018; RST = 1; cycle();
    RST = 0; repeat (2) cycle();
    set_idle(); repeat (4) cycle();
    // Random traffic: fields are only changed while req is low
    repeat (600) begin
      RST = ($urandom_range(0, 99) == 0);
      if (if_req) begin if ($urandom_range(0, 3) == 0) if_req = 0; end
      else if ($urandom_range(0, 1) == 1) begin if_req = 1; if_addr = rnd_addr(); end
      if (d_req) begin if ($urandom_range(0, 3) == 0) d_req = 0; end
      else if ($urandom_range(0, 1) == 1) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(1, 15));
        d_addr = rnd_addr(); d_wdata = $urandom;
      end
      if (x_req) begin if ($urandom_range(0, 3) == 0) x_req = 0; end
      else if ($urandom_range(0, 1) == 1) begin
        x_req = 1; x_we = 1'($urandom_range(0, 1)); x_be = 4'($urandom_range(1, 15));
        x_addr = rnd_addr(); x_wdata = $urandom;
      end
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
